// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// unsigned multiply, divide and remainder behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               ALU_CLK,
    input  logic               ALU_RST,
    input  logic               ALU_START,
    input  logic [3:0]         ALU_CTL,
    input  logic [WIDTH-1:0]   ALU_DA,
    input  logic [WIDTH-1:0]   ALU_DB,
    input  logic [SHIFT_W-1:0] ALU_SHIFT,
    output logic [WIDTH-1:0]   ALU_DC,
    output logic               ALU_OverFlow,
    output logic               ALU_DIVZERO,
    output logic               ALU_BUSY,
    output logic               ALU_DONE
);

    // state | meaning
    // IDLE  | waiting for ALU_START; single-cycle ops complete from here
    // ITER  | one multiply/divide step per cycle, counter 0..WIDTH-1
    typedef enum logic {IDLE, ITER} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    localparam logic [SHIFT_W-1:0] CNT_LAST = SHIFT_W'(WIDTH - 1);

    state_t               state;
    logic [SHIFT_W-1:0]   cnt;
    logic [3:0]           ctl_r;
    logic [WIDTH-1:0]     b_r;
    // Shared work register: {accumulator/remainder, multiplier/quotient}
    logic [2*WIDTH-1:0]   p;

    logic [WIDTH-1:0]     sc_res;
    logic                 sc_ov;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic                 is_iter;

    logic [WIDTH:0]       mul_s;
    logic [WIDTH:0]       div_t;
    logic [WIDTH:0]       div_d;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   p_next;

    assign sum     = ALU_DA + ALU_DB;
    assign diff    = ALU_DA - ALU_DB;
    assign is_iter = (ALU_CTL == OP_MUL) || (ALU_CTL == OP_DIVU) || (ALU_CTL == OP_REMU);

    always_comb begin
        sc_res = '0;
        sc_ov  = 1'b0;
        case (ALU_CTL)
            OP_ADD: begin
                sc_res = sum;
                sc_ov  = (ALU_DA[WIDTH-1] == ALU_DB[WIDTH-1]) && (sum[WIDTH-1] != ALU_DA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ov  = (ALU_DA[WIDTH-1] != ALU_DB[WIDTH-1]) && (diff[WIDTH-1] != ALU_DA[WIDTH-1]);
            end
            OP_AND:  sc_res = ALU_DA & ALU_DB;
            OP_OR:   sc_res = ALU_DA | ALU_DB;
            OP_XOR:  sc_res = ALU_DA ^ ALU_DB;
            OP_SLL:  sc_res = ALU_DA << ALU_SHIFT;
            OP_SRL:  sc_res = ALU_DA >> ALU_SHIFT;
            OP_SRA:  sc_res = WIDTH'($signed(ALU_DA) >>> ALU_SHIFT);
            default: sc_res = '0;
        endcase
    end

    // A zero divisor needs no special casing: every step subtracts nothing,
    // so the quotient fills with ones and the remainder ends up equal to DA.
    always_comb begin
        mul_s  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : (WIDTH+1)'(0));
        div_t  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_ge = (div_t >= {1'b0, b_r});
        div_d  = div_t - {1'b0, b_r};
        if (ctl_r == OP_MUL)
            p_next = {mul_s, p[WIDTH-1:1]};
        else
            p_next = {(div_ge ? div_d[WIDTH-1:0] : div_t[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge ALU_CLK or posedge ALU_RST) begin
        if (ALU_RST) begin
            state        <= IDLE;
            cnt          <= '0;
            ctl_r        <= '0;
            b_r          <= '0;
            p            <= '0;
            ALU_DC       <= '0;
            ALU_OverFlow <= 1'b0;
            ALU_DIVZERO  <= 1'b0;
            ALU_BUSY     <= 1'b0;
            ALU_DONE     <= 1'b0;
        end else begin
            ALU_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (ALU_START) begin
                        if (is_iter) begin
                            state <= ITER;
                            cnt   <= '0;
                            ctl_r <= ALU_CTL;
                            b_r   <= ALU_DB;
                            p     <= {{WIDTH{1'b0}}, ALU_DA};
                        end else begin
                            ALU_DC       <= sc_res;
                            ALU_OverFlow <= sc_ov;
                            ALU_DIVZERO  <= 1'b0;
                            ALU_DONE     <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        ALU_BUSY <= 1'b0;
                        ALU_DONE <= 1'b1;
                        case (ctl_r)
                            OP_MUL: begin
                                ALU_DC       <= p_next[WIDTH-1:0];
                                ALU_OverFlow <= |p_next[2*WIDTH-1:WIDTH];
                                ALU_DIVZERO  <= 1'b0;
                            end
                            OP_DIVU: begin
                                ALU_DC       <= p_next[WIDTH-1:0];
                                ALU_OverFlow <= 1'b0;
                                ALU_DIVZERO  <= (b_r == '0);
                            end
                            default: begin
                                ALU_DC       <= p_next[2*WIDTH-1:WIDTH];
                                ALU_OverFlow <= 1'b0;
                                ALU_DIVZERO  <= (b_r == '0);
                            end
                        endcase
                    end else begin
                        ALU_BUSY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, single-cycle ops, overflow, iterative
// multiply/divide latency and results, ignored starts, reset mid-operation.
module tb_alu_seq;

    localparam int WIDTH   = 16;
    localparam int SHIFT_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [3:0]         ctl = 4'b0;
    logic [WIDTH-1:0]   da = '0;
    logic [WIDTH-1:0]   db = '0;
    logic [SHIFT_W-1:0] sh = '0;
    logic [WIDTH-1:0]   dc;
    logic               ov;
    logic               dz;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
        .ALU_CLK(clk), .ALU_RST(rst), .ALU_START(start), .ALU_CTL(ctl),
        .ALU_DA(da), .ALU_DB(db), .ALU_SHIFT(sh), .ALU_DC(dc),
        .ALU_OverFlow(ov), .ALU_DIVZERO(dz), .ALU_BUSY(busy), .ALU_DONE(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] s,
                          input logic [15:0] exp_dc, input logic exp_ov);
        ctl = c; da = a; db = b; sh = s; start = 1'b1;
        step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_dc"}, 32'(dc), 32'(exp_dc));
        chk({tag, "_ov"}, 32'(ov), 32'(exp_ov));
    endtask

    task automatic iter(input string tag, input logic [3:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_dc,
                        input logic exp_ov, input logic exp_dz, input bit poke);
        int n;
        int busy_cnt;
        ctl = c; da = a; db = b; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (poke && n == 3) begin
                start = 1'b1; ctl = 4'b0000; da = 16'h0001; db = 16'h0001;
            end
            if (poke && n == 6) start = 1'b0;
            step();
            n++;
        end
        ctl = 4'hF; da = '0; db = '0;
        chk({tag, "_latency"}, 32'(n), 32'd16);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd15);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_dc"}, 32'(dc), 32'(exp_dc));
        chk({tag, "_ov"}, 32'(ov), 32'(exp_ov));
        chk({tag, "_dz"}, 32'(dz), 32'(exp_dz));
    endtask

    initial begin
        int seen;
        // asynchronous reset asserted mid-cycle, away from any edge
        #7 rst = 1'b1;
        #1;
        chk("rst_dc", 32'(dc), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();
        #3 rst = 1'b0;
        step();
        step();
        chk("idle_done", 32'(done), 32'd0);

        // back-to-back single-cycle ops with START held high
        single("add",  4'b0000, 16'hFFF0, 16'h0FF0, 4'd0, 16'h0FE0, 1'b0);
        single("and",  4'b0010, 16'hFFF0, 16'h0FF0, 4'd0, 16'h0FF0, 1'b0);
        single("or",   4'b0011, 16'hFFF0, 16'h0FF0, 4'd0, 16'hFFF0, 1'b0);
        single("xor",  4'b0100, 16'hFFF0, 16'h0FF0, 4'd0, 16'hF000, 1'b0);
        single("sra",  4'b0111, 16'hFFF0, 16'h0FF0, 4'd4, 16'hFFFF, 1'b0);
        single("sll",  4'b0101, 16'h8421, 16'h0000, 4'd3, 16'h2108, 1'b0);
        single("srl",  4'b0110, 16'h8421, 16'h0000, 4'd3, 16'h1084, 1'b0);
        single("subov", 4'b0001, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 1'b1);
        single("addov", 4'b0000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b1);
        single("nop",  4'b1100, 16'h1234, 16'h5678, 4'd0, 16'h0000, 1'b0);
        start = 1'b0;
        ctl = 4'b0000; da = 16'hAAAA; db = 16'h1111;
        step();
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_dc", 32'(dc), 32'd0);

        iter("mul1", 4'b1000, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        iter("mul2", 4'b1000, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        chk("post_mul_done", 32'(done), 32'd0);
        chk("post_mul_dc", 32'(dc), 32'd0);
        iter("divu",  4'b1001, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 1'b0);
        iter("remu",  4'b1010, 16'h0064, 16'h0007, 16'h0002, 1'b0, 1'b0, 1'b0);
        iter("divu0", 4'b1001, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        iter("remu0", 4'b1010, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0);

        // reset mid-MUL: everything clears at once and no DONE ever follows
        ctl = 4'b1000; da = 16'h00FF; db = 16'h0101; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dc", 32'(dc), 32'd0);
        chk("mid_rst_dz", 32'(dz), 32'd0);
        step();
        #3 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        single("add_after_rst", 4'b0000, 16'h0003, 16'h0004, 4'd0, 16'h0007, 1'b0);
        start = 1'b0;
        step();
        chk("final_done_low", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the 16-bit combinational ALU. It runs all single-cycle operations (add, sub, logic, shifts) with one registered cycle of latency. It also runs iterative unsigned multiply, divide and remainder over WIDTH cycles. Operation start and completion use a start/busy/done handshake. It sits in the execute stage and stalls the pipeline through ALU_BUSY.

## Interface
- WIDTH, 16: operand and result width (≥4, power of two).
- SHIFT_W, $clog2(WIDTH): shift-amount width.

- ALU_CLK  in  1  clock; all state updates on the rising edge.
- ALU_RST  in  1  reset, asynchronous, active-high.
- ALU_START  in  1  request; sampled only when ALU_BUSY=0.
- ALU_CTL  in  4  opcode:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA (single-cycle).
  - 1000 MUL, 1001 DIVU, 1010 REMU (iterative).
  - 1011–1111 NOP: result 0, single-cycle.
- ALU_DA  in  WIDTH  operand A, dividend, shift source.
- ALU_DB  in  WIDTH  operand B, divisor.
- ALU_SHIFT  in  SHIFT_W  shift amount.
- ALU_DC  out  WIDTH  registered result; held until the next completion.
- ALU_OverFlow  out  1  registered overflow flag, updated with ALU_DC.
- ALU_DIVZERO  out  1  registered divide-by-zero flag, updated with ALU_DC.
- ALU_BUSY  out  1  high while an iterative operation is in progress.
- ALU_DONE  out  1  one-cycle pulse; ALU_DC and the flags are new in this cycle.

## Operation
- **States:** IDLE, ITER.
- **Acceptance:** IDLE with ALU_START=1 accepts. ALU_CTL, ALU_DA, ALU_DB and ALU_SHIFT are captured at that edge. Later input changes do not affect the operation.
- **Single-cycle ops:** the result is written at the accept edge. ALU_DONE=1 for the following cycle. State stays IDLE.
- **ADD/SUB:** modulo 2^WIDTH. ALU_OverFlow is two's-complement signed overflow: operand signs equal (ADD) or different (SUB), and the result sign differs from DA.
- **AND/OR/XOR:** bitwise.
- **Shifts:** shift DA by ALU_SHIFT. SLL and SRL zero-fill. SRA replicates the sign bit.
- **Flags on non-ADD/SUB ops:** ALU_OverFlow=0, except MUL. ALU_DIVZERO=0, except DIVU/REMU.
- **Iterative ops:** the accept edge loads the internal registers, clears the iteration counter and enters ITER. ALU_BUSY=1 from the next cycle.
  - **MUL:** shift-add, unsigned, 2·WIDTH-bit product. ALU_DC = low half. ALU_OverFlow = 1 if the high half is nonzero.
  - **DIVU/REMU:** restoring division, one quotient bit per cycle. DIVU gives the quotient; REMU gives the remainder.
  - **Divisor 0:** DIVU gives all-ones, REMU gives DA, and ALU_DIVZERO=1. The full WIDTH cycles still run, so latency is fixed.
  - **Completion:** at the edge where counter = WIDTH-1, the result and flags are written, state returns to IDLE, and ALU_DONE pulses.
- ALU_START while ALU_BUSY=1 is ignored; no queuing.
- In the ALU_DONE cycle the state is IDLE, so a new ALU_START is accepted in that same cycle.

## Timing
- **Reset:** ALU_RST=1 forces the following immediately, including mid-ITER, with no completion pulse:
  - state IDLE and iteration counter 0;
  - ALU_DC=0, ALU_OverFlow=0, ALU_DIVZERO=0, ALU_BUSY=0, ALU_DONE=0.
- **After reset release:** the first rising edge with ALU_START=1 is accepted.
- **Single-cycle latency:** 1 cycle; throughput is one op per cycle with ALU_START held high.
- **Iterative latency:** WIDTH cycles from the accept edge to ALU_DONE. ALU_BUSY is high for WIDTH-1 cycles, then low in the ALU_DONE cycle.
- ALU_DC and the flags change only at completion edges or on reset.

## Test plan
- **Reset values:** assert ALU_RST mid-cycle (asynchronous). All outputs are 0 immediately; release, then DONE stays 0 with START=0.
- **Single-cycle ops** (WIDTH=16, DA=0xFFF0, DB=0x0FF0), one cycle apart:
  - ADD → DC=0x0FE0, OverFlow=0;
  - AND → 0x0FF0; OR → 0xFFF0; XOR → 0xF000;
  - SRA with SHIFT=4 → 0xFFFF;
  - each with DONE one cycle after accept.
- **Signed overflow:** SUB 0x8000−0x0001 → DC=0x7FFF, OverFlow=1. ADD 0x7FFF+0x0001 → DC=0x8000, OverFlow=1.
- **MUL:**
  - 0x00FF×0x0101 → DC=0xFFFF, OverFlow=0;
  - 0x0100×0x0100 → DC=0x0000, OverFlow=1;
  - DONE exactly 16 cycles after accept; START pulses during BUSY are ignored (result unchanged).
- **Division:**
  - DIVU 0x0064/0x0007 → 0x000E;
  - REMU → 0x0002;
  - DIVU 0x1234/0 → 0xFFFF with DIVZERO=1;
  - REMU 0x1234/0 → 0x1234, DIVZERO=1.
- **Reset mid-op:** assert ALU_RST 8 cycles into a MUL. BUSY and DC go to 0 immediately and no DONE follows. A new ADD after release completes normally in 1 cycle.
